// File: rtl/alu_response_checker.sv
// Bring-up monitor for the ALU: re-computes each sampled ALU operation with a golden
// model, counts checks/skips/mismatches and captures the first failing transaction.
module alu_response_checker #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NUM_CHECKS = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic [31:0]      A,
  input  logic [31:0]      B,
  input  logic [3:0]       ALUop,
  input  logic [31:0]      ALUout,
  input  logic             ZeroFlag,
  input  logic             BLT,
  input  logic             BGT,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] skip_count,
  output logic [CNT_W-1:0] error_count,
  output logic             err_latched,
  output logic [3:0]       first_err_op,
  output logic [31:0]      first_err_got,
  output logic [31:0]      first_err_exp
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;

  // Stage 1: registered ALU traffic
  logic        s1_v_q;
  logic [31:0] s1_a_q, s1_b_q, s1_out_q;
  logic [3:0]  s1_op_q;
  logic        s1_z_q, s1_lt_q, s1_gt_q;

  // Stage 2: comparison result
  logic        s2_v_q, s2_skip_q, s2_mism_q;
  logic [3:0]  s2_op_q;
  logic [31:0] s2_got_q, s2_exp_q;

  // Samples accepted / retired since start; separate from the saturating outputs
  // so the run length is still honoured once a visible counter pins at all-ones.
  logic [31:0] acc_q, ret_q;

  logic        accept, run_full;
  logic [31:0] exp_out, exp_rep;
  logic        exp_skip, exp_mism;
  logic [4:0]  sh;
  logic        lt_s, gt_s, lt_u, gt_u, eq;

  assign accept   = (state_q == S_RUN) && sample_valid && !start &&
                    ((NUM_CHECKS == 0) || (acc_q < NUM_CHECKS));
  assign run_full = (NUM_CHECKS != 0) && (ret_q >= NUM_CHECKS);

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign pass = done && (error_count == '0) && (check_count != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (start) state_d = S_RUN;
               else if (stop || run_full) state_d = S_DRAIN;
      S_DRAIN: if (start) state_d = S_RUN;
               else state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    sh       = s1_b_q[4:0];
    lt_s     = $signed(s1_a_q) < $signed(s1_b_q);
    gt_s     = $signed(s1_a_q) > $signed(s1_b_q);
    lt_u     = s1_a_q < s1_b_q;
    gt_u     = s1_a_q > s1_b_q;
    eq       = s1_a_q == s1_b_q;
    exp_out  = '0;
    exp_rep  = '0;
    exp_skip = 1'b0;
    exp_mism = 1'b0;
    case (s1_op_q)
      4'b0000: exp_out = s1_a_q + s1_b_q;
      4'b0001: exp_out = s1_a_q - s1_b_q;
      4'b0010: exp_out = s1_a_q << sh;
      4'b0011: exp_out = s1_a_q >> sh;
      4'b0100: exp_out = $unsigned($signed(s1_a_q) >>> sh);
      4'b0101: exp_out = s1_a_q & s1_b_q;
      4'b0110: exp_out = s1_a_q | s1_b_q;
      4'b0111: exp_out = s1_a_q ^ s1_b_q;
      4'b1100: exp_out = s1_a_q * s1_b_q;
      4'b1000: exp_mism = (s1_lt_q != lt_s) || (s1_gt_q != gt_s) || (s1_z_q != eq);
      4'b1001: exp_mism = (s1_lt_q != lt_u) || (s1_gt_q != gt_u) || (s1_z_q != eq);
      default: exp_skip = 1'b1;
    endcase
    if (!exp_skip && (s1_op_q != 4'b1000) && (s1_op_q != 4'b1001)) begin
      exp_rep  = exp_out;
      exp_mism = (s1_out_q != exp_out) || (s1_z_q != (exp_out == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      s1_v_q        <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_out_q      <= '0;
      s1_op_q       <= '0;
      s1_z_q        <= 1'b0;
      s1_lt_q       <= 1'b0;
      s1_gt_q       <= 1'b0;
      s2_v_q        <= 1'b0;
      s2_skip_q     <= 1'b0;
      s2_mism_q     <= 1'b0;
      s2_op_q       <= '0;
      s2_got_q      <= '0;
      s2_exp_q      <= '0;
      acc_q         <= '0;
      ret_q         <= '0;
      check_count   <= '0;
      skip_count    <= '0;
      error_count   <= '0;
      err_latched   <= 1'b0;
      first_err_op  <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_a_q   <= A;
        s1_b_q   <= B;
        s1_out_q <= ALUout;
        s1_op_q  <= ALUop;
        s1_z_q   <= ZeroFlag;
        s1_lt_q  <= BLT;
        s1_gt_q  <= BGT;
        if (NUM_CHECKS != 0) acc_q <= acc_q + 32'd1;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_skip_q <= exp_skip;
        s2_mism_q <= exp_mism;
        s2_op_q   <= s1_op_q;
        s2_got_q  <= s1_out_q;
        s2_exp_q  <= exp_rep;
      end
      if (s2_v_q) begin
        if (ret_q != '1) ret_q <= ret_q + 32'd1;
        if (s2_skip_q) begin
          if (skip_count != '1) skip_count <= skip_count + CNT_ONE;
        end else begin
          if (check_count != '1) check_count <= check_count + CNT_ONE;
          if (s2_mism_q) begin
            if (error_count != '1) error_count <= error_count + CNT_ONE;
            if (!err_latched) begin
              err_latched   <= 1'b1;
              first_err_op  <= s2_op_q;
              first_err_got <= s2_got_q;
              first_err_exp <= s2_exp_q;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_response_checker.sv
// Scoreboard bench for alu_response_checker: directed ALU traffic with hand-computed
// results; a monitor pairs each counter retirement with the queued expectation.
module tb_alu_response_checker;

  logic        clk, reset, start, stop, sample_valid;
  logic [31:0] A, B, ALUout;
  logic [3:0]  ALUop;
  logic        ZeroFlag, BLT, BGT;
  logic        busy, done, pass, err_latched;
  logic [15:0] check_count, skip_count, error_count;
  logic [3:0]  first_err_op;
  logic [31:0] first_err_got, first_err_exp;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic skip;
    logic err;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] prev_chk = '0, prev_skip = '0, prev_err = '0;

  logic [3:0]  t1_op  [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC};
  logic [31:0] t1_out [11] = '{32'd15, 32'hFFFF_FFF7, 32'h0000_3000, 32'h0, 32'h0, 32'h0,
                               32'hF, 32'hF, 32'h0, 32'h0, 32'd36};
  logic        t1_z   [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        t1_lt  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  alu_response_checker #(.CNT_W(16), .NUM_CHECKS(11)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_valid(sample_valid),
    .A(A), .B(B), .ALUop(ALUop), .ALUout(ALUout),
    .ZeroFlag(ZeroFlag), .BLT(BLT), .BGT(BGT),
    .busy(busy), .done(done), .pass(pass),
    .check_count(check_count), .skip_count(skip_count), .error_count(error_count),
    .err_latched(err_latched), .first_err_op(first_err_op),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: one retirement per cycle shows up as a +1 on check_count or skip_count.
  always @(negedge clk) begin
    exp_t e;
    if (check_count < prev_chk || skip_count < prev_skip || error_count < prev_err) begin
      // counters cleared by reset or start
    end else if (check_count != prev_chk || skip_count != prev_skip) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL retire_unexpected got=chk%0d/skip%0d exp=no retirement",
                 check_count, skip_count);
      end else begin
        e = exp_q.pop_front();
        check("retire_kind",
              {61'b0, check_count != prev_chk, skip_count != prev_skip, error_count != prev_err},
              {61'b0, !e.skip, e.skip, e.err});
      end
    end
    prev_chk  = check_count;
    prev_skip = skip_count;
    prev_err  = error_count;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] out, input logic z, input logic lt, input logic gt,
                      input logic e_skip, input logic e_err, input logic push);
    exp_t e;
    A = a; B = b; ALUop = op; ALUout = out; ZeroFlag = z; BLT = lt; BGT = gt;
    sample_valid = 1'b1;
    if (push) begin
      e.skip = e_skip;
      e.err  = e_err;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {63'b0, done}, 64'd1);
  endtask

  task automatic run_basic(input logic inject);
    for (int i = 0; i < 11; i++) begin
      if (inject && i == 0)
        send(32'd3, 32'd12, t1_op[i], 32'd16, 1'b0, t1_lt[i], 1'b0, 1'b0, 1'b1, 1'b1);
      else
        send(32'd3, 32'd12, t1_op[i], t1_out[i], t1_z[i], t1_lt[i], 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    A = '0; B = '0; ALUop = '0; ALUout = '0; ZeroFlag = 1'b0; BLT = 1'b0; BGT = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {56'b0, busy, done, pass, err_latched, first_err_op}, 64'd0);
    check("reset_counts", {16'b0, check_count, skip_count, error_count}, 64'd0);
    check("reset_first_err", {first_err_got, first_err_exp}, 64'd0);
    reset = 1'b0;

    // Correct ALU, run ends automatically after 11 samples
    pulse_start();
    check("t1_busy", {63'b0, busy}, 64'd1);
    run_basic(1'b0);
    wait_done("t1_done");
    check("t1_counts", {16'b0, check_count, skip_count, error_count}, {16'b0, 16'd11, 16'd0, 16'd0});
    check("t1_pass", {62'b0, pass, err_latched}, 64'd2);
    send(32'd1, 32'd1, 4'h0, 32'd99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_ignores", {48'b0, check_count}, 64'd11);

    // Wrong result on the add
    pulse_start();
    run_basic(1'b1);
    wait_done("t2_done");
    check("t2_counts", {16'b0, check_count, skip_count, error_count}, {16'b0, 16'd11, 16'd0, 16'd1});
    check("t2_first_err", {28'b0, first_err_op, first_err_got}, {28'b0, 4'h0, 32'd16});
    check("t2_first_exp", {32'b0, first_err_exp}, 64'd15);
    check("t2_pass_latched", {62'b0, pass, err_latched}, 64'd1);

    // Branch compares: ALUout ignored; wrong BLT on unsigned compare
    pulse_start();
    send(32'hFFFF_FFFF, 32'd1, 4'h8, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'd1, 4'h9, 32'h5678, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_stop();
    wait_done("t3_done");
    check("t3_counts", {16'b0, check_count, skip_count, error_count}, {16'b0, 16'd2, 16'd0, 16'd1});
    check("t3_first_err", {28'b0, first_err_op, first_err_got}, {28'b0, 4'h9, 32'h5678});
    check("t3_first_exp", {32'b0, first_err_exp}, 64'd0);

    // Shifts of a negative operand and an unchecked opcode
    pulse_start();
    send(32'h8000_0000, 32'd4, 4'h4, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'd4, 4'h3, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'd4, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_stop();
    wait_done("t4_done");
    check("t4_counts", {16'b0, check_count, skip_count, error_count}, {16'b0, 16'd2, 16'd1, 16'd0});
    check("t4_pass", {63'b0, pass}, 64'd1);

    // Stop right behind a sample: the sample still retires during DRAIN
    pulse_start();
    send(32'd1, 32'd1, 4'h0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_stop();
    check("t5_drain", {62'b0, busy, done}, 64'd2);
    @(posedge clk); #1;
    check("t5_done_2cyc", {62'b0, busy, done}, 64'd1);
    check("t5_count", {48'b0, check_count}, 64'd1);

    // Reset mid-run with a sample in flight
    pulse_start();
    for (int i = 0; i < 5; i++)
      send(32'd3, 32'd12, t1_op[i], t1_out[i], t1_z[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_five", {47'b0, busy, check_count}, {47'b0, 1'b1, 16'd5});
    send(32'd5, 32'd6, 4'h0, 32'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_reset_flags", {56'b0, busy, done, pass, err_latched, first_err_op}, 64'd0);
    check("t6_reset_counts", {16'b0, check_count, skip_count, error_count}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_discarded", {16'b0, check_count, skip_count, error_count}, 64'd0);
    pulse_start();
    check("t6_fresh_zero", {47'b0, busy, check_count}, {47'b0, 1'b1, 16'd0});
    send(32'd7, 32'd7, 4'h1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    pulse_stop();
    wait_done("t6_done");
    check("t6_fresh_count", {48'b0, check_count}, 64'd1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
